// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared state encoding and counter-width helper for serial_cmp_n
// Purpose: FSM state codes and the mismatch/beat counter width calculation.
// Ports: none (package).
package cmp_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Smallest n with 2**n >= width+1, so a counter can hold 0..width.
  function automatic int calc_cw(input int width);
    int n;
    n = 0;
    while ((1 << n) < (width + 1)) n++;
    return n;
  endfunction

endpackage

// File: rtl/bit_cnt.sv
// rtl/bit_cnt.sv - CW-bit up-counter with sync clear, enable and terminal flag
// Purpose: counts enabled cycles from 0 up to LIMIT.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   clr         synchronous clear (wins over en)
//   en          increment this cycle
//   cnt_nxt     value the counter takes on the next edge
//   term        this enabled increment brings the count to LIMIT
module bit_cnt #(
  parameter int LIMIT = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt_nxt,
  output logic          term
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  assign cnt_nxt = cnt_d;
  assign term    = en && !clr && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_cmp_n.sv
// rtl/serial_cmp_n.sv - sequential comparator of two WIDTH-bit serial operands
// Purpose: accepts one a/b bit pair per bit_valid beat and, after WIDTH beats,
//          reports equal / a_gt_b / a_lt_b and the number of differing bits.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   start        request a new comparison (honoured only in IDLE)
//   bit_valid    a/b carry a valid bit pair this cycle
//   a, b         serial operand bits
//   busy         comparison in progress
//   done         one-cycle pulse, results valid
//   equal, a_gt_b, a_lt_b, mism_cnt   held results of the last comparison
module serial_cmp_n
  import cmp_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int CW        = calc_cw(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          bit_valid,
  input  logic          a,
  input  logic          b,
  output logic          busy,
  output logic          done,
  output logic          equal,
  output logic          a_gt_b,
  output logic          a_lt_b,
  output logic [CW-1:0] mism_cnt
);

  logic [1:0]    state_q, state_d;
  logic          gt_q, gt_d, lt_q, lt_d;
  logic          eq_res_q, eq_res_d, gt_res_q, gt_res_d, lt_res_q, lt_res_d;
  logic [CW-1:0] mism_res_q, mism_res_d;

  logic          accept, beat, diff, last;
  logic [CW-1:0] beat_nxt_unused, mism_nxt;
  logic          mism_full_unused;

  assign accept = (state_q == S_IDLE) && start;
  assign beat   = (state_q == S_RUN) && bit_valid;
  assign diff   = a ^ b;

  bit_cnt #(.LIMIT(WIDTH), .CW(CW)) u_beat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (beat),
    .cnt_nxt (beat_nxt_unused),
    .term    (last)
  );

  bit_cnt #(.LIMIT(WIDTH), .CW(CW)) u_mism_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (beat && diff),
    .cnt_nxt (mism_nxt),
    .term    (mism_full_unused)
  );

  // Order flags: MSB-first keeps the first difference, LSB-first lets each
  // later difference overwrite since it is more significant.
  always_comb begin
    gt_d = gt_q;
    lt_d = lt_q;
    if (accept) begin
      gt_d = 1'b0;
      lt_d = 1'b0;
    end else if (beat && diff && (!MSB_FIRST || !(gt_q || lt_q))) begin
      gt_d = a;
      lt_d = !a;
    end
  end

  // Results are published only on the edge consuming the last bit, using the
  // next-state values so that bit is included.
  always_comb begin
    eq_res_d   = eq_res_q;
    gt_res_d   = gt_res_q;
    lt_res_d   = lt_res_q;
    mism_res_d = mism_res_q;
    if (accept) begin
      eq_res_d   = 1'b0;
      gt_res_d   = 1'b0;
      lt_res_d   = 1'b0;
      mism_res_d = '0;
    end else if (last) begin
      eq_res_d   = (mism_nxt == '0);
      gt_res_d   = gt_d;
      lt_res_d   = lt_d;
      mism_res_d = mism_nxt;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last)   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gt_q       <= 1'b0;
      lt_q       <= 1'b0;
      eq_res_q   <= 1'b0;
      gt_res_q   <= 1'b0;
      lt_res_q   <= 1'b0;
      mism_res_q <= '0;
    end else begin
      state_q    <= state_d;
      gt_q       <= gt_d;
      lt_q       <= lt_d;
      eq_res_q   <= eq_res_d;
      gt_res_q   <= gt_res_d;
      lt_res_q   <= lt_res_d;
      mism_res_q <= mism_res_d;
    end
  end

  assign equal    = eq_res_q;
  assign a_gt_b   = gt_res_q;
  assign a_lt_b   = lt_res_q;
  assign mism_cnt = mism_res_q;

endmodule

// File: tb/tb_serial_cmp_n.sv
// tb/tb_serial_cmp_n.sv - self-checking bench for serial_cmp_n (MSB- and LSB-first instances)
module tb_serial_cmp_n;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;

  logic       m_busy, m_done, m_eq, m_gt, m_lt;
  logic [3:0] m_cnt;
  logic       l_busy, l_done, l_eq, l_gt, l_lt;
  logic [3:0] l_cnt;

  serial_cmp_n #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid), .a(a), .b(b),
    .busy(m_busy), .done(m_done), .equal(m_eq), .a_gt_b(m_gt), .a_lt_b(m_lt), .mism_cnt(m_cnt)
  );

  serial_cmp_n #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid), .a(a), .b(b),
    .busy(l_busy), .done(l_done), .equal(l_eq), .a_gt_b(l_gt), .a_lt_b(l_lt), .mism_cnt(l_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream values are sent MSB first; the LSB-first instance therefore sees
  // the bit-reversed operands, and its expectations are written for those.
  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       m_eq, m_gt, m_lt;
    logic [3:0] cnt;
    logic       l_eq, l_gt, l_lt;
  } vec_t;

  typedef struct {
    vec_t v;
    int   s_edge;
    int   lat;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t tbl[8];

  always @(negedge clk) begin
    chk("done_align", l_done, m_done);
    if (m_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("latency", cyc - mon_e.s_edge, mon_e.lat);
        chk("m_busy_at_done", m_busy, 0);
        chk("m_equal", m_eq, mon_e.v.m_eq);
        chk("m_gt", m_gt, mon_e.v.m_gt);
        chk("m_lt", m_lt, mon_e.v.m_lt);
        chk("m_mism", m_cnt, mon_e.v.cnt);
        chk("l_equal", l_eq, mon_e.v.l_eq);
        chk("l_gt", l_gt, mon_e.v.l_gt);
        chk("l_lt", l_lt, mon_e.v.l_lt);
        chk("l_mism", l_cnt, mon_e.v.cnt);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int gap_len, input int restart_beat, input bit start_with_bit);
    sb_t e;
    int  n;
    int  k;
    @(negedge clk);
    start     = 1'b1;
    bit_valid = start_with_bit;
    a         = 1'b1;
    b         = 1'b0;
    e.v      = v;
    e.s_edge = cyc + 1;
    e.lat    = W + 2 * gap_len;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      k = W - i;
      bit_valid = 1'b1;
      a         = v.va[i];
      b         = v.vb[i];
      start     = (k == restart_beat);
      chk("busy_run", m_busy, 1);
      @(negedge clk);
      if (gap_len > 0 && (k == 2 || k == 5)) begin
        start     = 1'b0;
        bit_valid = 1'b0;
        repeat (gap_len) begin
          a = 1'($urandom);
          b = 1'($urandom);
          chk("busy_gap", m_busy, 1);
          @(negedge clk);
        end
      end
    end
    start     = 1'b0;
    bit_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
    chk("done_pulse", m_done, 0);
    chk("hold_eq", m_eq, v.m_eq);
    chk("hold_gt", m_gt, v.m_gt);
    chk("hold_lt", m_lt, v.m_lt);
    chk("hold_mism", m_cnt, v.cnt);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{8'h3C, 8'h3D, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'h80, 8'h40, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'hF0, 8'h0F, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h55, 8'h55, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{8'hFF, 8'hFE, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};

    #12;
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_eq", m_eq, 0);
    chk("rst_gt", m_gt, 0);
    chk("rst_lt", m_lt, 0);
    chk("rst_mism", m_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], 0, -1, 1'b0);

    // gaps of 3 idle cycles after beats 2 and 5
    run_vec(tbl[4], 3, -1, 1'b0);
    // start re-pulsed together with beat 4
    run_vec(tbl[1], 0, 4, 1'b0);
    // bit_valid with start in IDLE carries a=1,b=0 that must not be counted
    run_vec(tbl[0], 0, -1, 1'b1);

    // reset in the middle of a run
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bit_valid = 1'b1;
      a = k[0];
      b = ~k[0];
      @(negedge clk);
    end
    bit_valid = 1'b0;
    chk("busy_before_rst", m_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", m_busy, 0);
    chk("async_l_busy", l_busy, 0);
    chk("async_done", m_done, 0);
    chk("async_eq", m_eq, 0);
    chk("async_gt", m_gt, 0);
    chk("async_lt", m_lt, 0);
    chk("async_mism", m_cnt, 0);
    @(negedge clk);
    chk("rst_hold_busy", m_busy, 0);
    rst_n = 1'b1;
    run_vec(tbl[5], 0, -1, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
